// File: rtl/mips_mem_pkg.sv
// Shared definitions for the load/store unit: size codes, FSM encoding and
// the lane-select / store-replication helpers used by the RAM-side datapath.
package mips_mem_pkg;

  localparam int DATA_W = 32;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_RESP   = 2'b10
  } state_t;

  // Size code 11 and any access not aligned to its own width is rejected.
  function automatic logic req_fault(input logic [1:0] size, input logic [1:0] off);
    logic f;
    case (size)
      SZ_BYTE: f = 1'b0;
      SZ_HALF: f = off[0];
      SZ_WORD: f = (off != 2'b00);
      default: f = 1'b1;
    endcase
    return f;
  endfunction

  function automatic logic [3:0] lane_sel(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] s;
    case (size)
      SZ_BYTE: s = 4'b0001 << off;
      SZ_HALF: s = off[1] ? 4'b1100 : 4'b0011;
      default: s = 4'b1111;
    endcase
    return s;
  endfunction

  function automatic logic [DATA_W-1:0] store_data(input logic [1:0] size,
                                                   input logic [DATA_W-1:0] wdata);
    logic [DATA_W-1:0] d;
    case (size)
      SZ_BYTE: d = {4{wdata[7:0]}};
      SZ_HALF: d = {2{wdata[15:0]}};
      default: d = wdata;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/load_align.sv
// Moves the addressed byte/half of a RAM word down to bit 0 and extends it
// to 32 bits, sign- or zero-filling according to the unsigned flag.
module load_align
  import mips_mem_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  offset_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  output logic [31:0] data_o
);

  logic        [31:0] shifted;
  logic signed [7:0]  byte_s;
  logic signed [15:0] half_s;
  logic signed [31:0] ext_s;

  always_comb begin
    shifted = rdata_i >> {offset_i, 3'b000};
    byte_s  = shifted[7:0];
    half_s  = shifted[15:0];
    ext_s   = '0;
    data_o  = rdata_i;
    case (size_i)
      SZ_BYTE: begin
        ext_s  = byte_s;
        data_o = unsigned_i ? {24'h0, shifted[7:0]} : ext_s;
      end
      SZ_HALF: begin
        ext_s  = half_s;
        data_o = unsigned_i ? {16'h0, shifted[15:0]} : ext_s;
      end
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Three-state load/store unit between the pipeline and a byte-lane RAM:
// IDLE accepts, ACCESS drives the RAM, RESP returns data or a fault.
module mem_access_unit
  import mips_mem_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_fault,
  output logic        ram_enabler,
  output logic        ram_write_enabler,
  output logic [31:0] ram_addr,
  output logic [3:0]  ram_select,
  output logic [31:0] ram_data_input,
  input  logic [31:0] ram_data_output
);

  state_t state_q, state_d;

  logic        write_q, unsigned_q, fault_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q, wdata_q;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] aligned;
  logic        accept, in_access;

  assign accept    = req_valid && req_ready;
  assign in_access = (state_q == ST_ACCESS);

  // Async reset drops the state out of ACCESS immediately, so an in-flight
  // store never sees a write enable on the following clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (accept) state_d = req_fault(req_size, req_addr[1:0]) ? ST_RESP : ST_ACCESS;
      ST_ACCESS: state_d = ST_RESP;
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      write_q    <= req_write;
      size_q     <= req_size;
      unsigned_q <= req_unsigned;
      addr_q     <= req_addr;
      wdata_q    <= req_wdata;
      fault_q    <= req_fault(req_size, req_addr[1:0]);
    end
    if (in_access) rdata_q <= rdata_d;
  end

  load_align u_load_align (
    .rdata_i    (ram_data_output),
    .offset_i   (addr_q[1:0]),
    .size_i     (size_q),
    .unsigned_i (unsigned_q),
    .data_o     (aligned)
  );

  assign rdata_d = write_q ? 32'h0 : aligned;

  assign req_ready         = (state_q == ST_IDLE) && !rst;
  assign ram_enabler       = in_access;
  assign ram_write_enabler = in_access && write_q;
  assign ram_addr          = in_access ? {addr_q[31:2], 2'b00} : 32'h0;
  assign ram_select        = in_access ? lane_sel(size_q, addr_q[1:0]) : 4'h0;
  assign ram_data_input    = (in_access && write_q) ? store_data(size_q, wdata_q) : 32'h0;

  // Response fields are only meaningful during RESP; a fault always reads 0.
  assign resp_valid = (state_q == ST_RESP);
  assign resp_fault = (state_q == ST_RESP) && fault_q;
  assign resp_rdata = ((state_q == ST_RESP) && !fault_q) ? rdata_q : 32'h0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit with a byte-lane RAM model.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_fault;
  logic [31:0] resp_rdata;
  logic        ram_enabler, ram_write_enabler;
  logic [31:0] ram_addr, ram_data_input, ram_data_output;
  logic [3:0]  ram_select;

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_fault(resp_fault),
    .ram_enabler(ram_enabler), .ram_write_enabler(ram_write_enabler),
    .ram_addr(ram_addr), .ram_select(ram_select),
    .ram_data_input(ram_data_input), .ram_data_output(ram_data_output)
  );

  logic [31:0] mem [0:1023];
  int cyc;

  assign ram_data_output = mem[ram_addr[11:2]];

  always @(posedge clk) begin
    if (rst) begin
      cyc <= 0;
      for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
      mem[10'h080] <= 32'h11223344;
      mem[10'h0C0] <= 32'h55667788;
      mem[10'h100] <= 32'h12345678;
    end else begin
      cyc <= cyc + 1;
      if (ram_enabler && ram_write_enabler)
        for (int k = 0; k < 4; k++)
          if (ram_select[k]) mem[ram_addr[11:2]][8*k +: 8] <= ram_data_input[8*k +: 8];
    end
  end

  typedef struct { logic fault; logic [31:0] rdata; int cyc; } resp_exp_t;
  typedef struct { logic we; logic [31:0] addr; logic [3:0] sel; logic [31:0] din; } ram_exp_t;

  resp_exp_t resp_q[$];
  ram_exp_t  ram_q[$];
  resp_exp_t m_re;
  ram_exp_t  m_ra;
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a response or RAM access.
  always @(negedge clk) begin
    if (!rst) begin
      if (resp_valid) begin
        if (resp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_resp: got fault=%0b rdata=0x%08h expected no response", resp_fault, resp_rdata);
        end else begin
          m_re = resp_q.pop_front();
          check32("resp_fault", {31'h0, resp_fault}, {31'h0, m_re.fault});
          check32("resp_rdata", resp_rdata, m_re.rdata);
          check32("resp_cycle", cyc, m_re.cyc);
        end
      end
      if (ram_enabler) begin
        if (ram_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_ram_access: got addr=0x%08h sel=%b expected no access", ram_addr, ram_select);
        end else begin
          m_ra = ram_q.pop_front();
          check32("ram_we", {31'h0, ram_write_enabler}, {31'h0, m_ra.we});
          check32("ram_addr", ram_addr, m_ra.addr);
          check32("ram_select", {28'h0, ram_select}, {28'h0, m_ra.sel});
          if (m_ra.we) check32("ram_data_input", ram_data_input, m_ra.din);
        end
      end
    end
  end

  task automatic push_exp(input logic wr, input logic [31:0] addr, input logic flt,
                          input logic [31:0] exp_rd, input logic [3:0] sel, input logic [31:0] din);
    resp_exp_t re;
    ram_exp_t  ra;
    re.fault = flt; re.rdata = exp_rd; re.cyc = cyc + (flt ? 1 : 2);
    resp_q.push_back(re);
    if (!flt) begin
      ra.we = wr; ra.addr = {addr[31:2], 2'b00}; ra.sel = sel; ra.din = din;
      ram_q.push_back(ra);
    end
  endtask

  task automatic wait_ready(output logic ok);
    int waited = 0;
    @(negedge clk);
    while (!req_ready && waited < 20) begin @(negedge clk); waited++; end
    ok = req_ready;
    if (!ok) begin
      n_cmp++; n_bad++;
      $display("FAIL ready_timeout: got req_ready=0 expected 1 within 20 cycles");
    end
  endtask

  task automatic drive(input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd);
    req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wd;
  endtask

  task automatic issue(input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd, input logic flt,
                       input logic [31:0] exp_rd, input logic [3:0] sel, input logic [31:0] din);
    logic ok;
    wait_ready(ok);
    if (ok) begin
      drive(wr, sz, uns, addr, wd);
      push_exp(wr, addr, flt, exp_rd, sel, din);
      @(posedge clk);
      #1 req_valid = 1'b0;
    end
  endtask

  initial begin
    logic ok;
    int acc;
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    repeat (3) @(negedge clk);
    check32("rst_req_ready", {31'h0, req_ready}, 32'h0);
    check32("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    check32("rst_ram_enabler", {31'h0, ram_enabler}, 32'h0);
    check32("rst_resp_rdata", resp_rdata, 32'h0);
    check32("rst_ram_addr", ram_addr, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    check32("post_rst_req_ready", {31'h0, req_ready}, 32'h1);

    // Word, byte and half stores/loads with sign and zero extension.
    issue(1, 2'b10, 0, 32'h100, 32'hDEADBEEF, 0, 32'h0,        4'b1111, 32'hDEADBEEF);
    issue(0, 2'b10, 0, 32'h100, 32'h0,        0, 32'hDEADBEEF, 4'b1111, 32'h0);
    issue(1, 2'b00, 0, 32'h203, 32'h000000A5, 0, 32'h0,        4'b1000, 32'hA5A5A5A5);
    issue(0, 2'b00, 0, 32'h203, 32'h0,        0, 32'hFFFFFFA5, 4'b1000, 32'h0);
    issue(0, 2'b00, 1, 32'h203, 32'h0,        0, 32'h000000A5, 4'b1000, 32'h0);
    issue(1, 2'b01, 0, 32'h302, 32'h00008001, 0, 32'h0,        4'b1100, 32'h80018001);
    issue(0, 2'b01, 0, 32'h302, 32'h0,        0, 32'hFFFF8001, 4'b1100, 32'h0);
    issue(0, 2'b01, 1, 32'h302, 32'h0,        0, 32'h00008001, 4'b1100, 32'h0);
    issue(1, 2'b00, 0, 32'h201, 32'hFFFFFF3C, 0, 32'h0,        4'b0010, 32'h3C3C3C3C);
    issue(0, 2'b00, 1, 32'h201, 32'h0,        0, 32'h0000003C, 4'b0010, 32'h0);
    issue(0, 2'b10, 0, 32'h200, 32'h0,        0, 32'hA5223C44, 4'b1111, 32'h0);
    issue(0, 2'b01, 0, 32'h200, 32'h0,        0, 32'h00003C44, 4'b0011, 32'h0);
    issue(0, 2'b01, 0, 32'h202, 32'h0,        0, 32'hFFFFA522, 4'b1100, 32'h0);

    // Faulting requests: misaligned word/half, illegal size, misaligned store.
    issue(0, 2'b10, 0, 32'h102, 32'h0,        1, 32'h0, 4'h0, 32'h0);
    issue(0, 2'b01, 0, 32'h101, 32'h0,        1, 32'h0, 4'h0, 32'h0);
    issue(0, 2'b11, 0, 32'h100, 32'h0,        1, 32'h0, 4'h0, 32'h0);
    issue(1, 2'b01, 0, 32'h303, 32'h0000FFFF, 1, 32'h0, 4'h0, 32'h0);
    issue(0, 2'b10, 0, 32'h300, 32'h0,        0, 32'h80017788, 4'b1111, 32'h0);

    // Reset pulsed inside the ACCESS cycle of a store.
    wait_ready(ok);
    if (ok) begin
      drive(1, 2'b10, 0, 32'h400, 32'hCAFEF00D);
      @(posedge clk);
      #1 req_valid = 1'b0;
      check32("access_ram_enabler", {31'h0, ram_enabler}, 32'h1);
      #1 rst = 1'b1;
      #1;
      check32("midrst_ram_enabler", {31'h0, ram_enabler}, 32'h0);
      check32("midrst_ram_we", {31'h0, ram_write_enabler}, 32'h0);
      check32("midrst_req_ready", {31'h0, req_ready}, 32'h0);
      check32("midrst_resp_valid", {31'h0, resp_valid}, 32'h0);
      #1 rst = 1'b0;
    end
    issue(0, 2'b10, 0, 32'h400, 32'h0, 0, 32'h12345678, 4'b1111, 32'h0);

    // req_valid held high for 9 cycles: one acceptance every 3 cycles.
    wait_ready(ok);
    acc = 0;
    for (int i = 0; i < 9; i++) begin
      if (i > 0) @(negedge clk);
      check32("hold_req_ready", {31'h0, req_ready}, (i % 3 == 0) ? 32'h1 : 32'h0);
      if (req_ready) begin
        acc++;
        push_exp(0, 32'h100, 0, 32'hDEADBEEF, 4'b1111, 32'h0);
      end
      drive(0, 2'b10, 0, 32'h100, 32'h0);
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    check32("hold_accept_count", acc, 32'd3);

    for (int i = 0; i < 50 && (resp_q.size() != 0 || ram_q.size() != 0); i++) @(negedge clk);
    repeat (3) @(negedge clk);
    check32("resp_queue_drained", resp_q.size(), 32'h0);
    check32("ram_queue_drained", ram_q.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no completion expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have port clk, input, 1: sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-003 SHALL have port req_valid, input, 1: pipeline presents a memory request.
REQ-004 SHALL have port req_ready, output, 1: unit accepts a request this cycle.
REQ-005 SHALL have port req_write, input, 1: 1 = store, 0 = load.
REQ-006 SHALL have port req_size, input, 2: 00 byte, 01 half, 10 word, 11 illegal.
REQ-007 SHALL have port req_unsigned, input, 1: zero-extend load data (ignored for stores and word loads).
REQ-008 SHALL have port req_addr, input, 32: byte address.
REQ-009 SHALL have port req_wdata, input, 32: store data, right-justified.
REQ-010 SHALL have port resp_valid, output, 1: one-cycle completion pulse.
REQ-011 SHALL have port resp_rdata, output, 32: extended load data; 0 for stores and faults.
REQ-012 SHALL have port resp_fault, output, 1: misaligned or illegal-size request, valid with resp_valid.
REQ-013 SHALL have ports ram_enabler (out, 1), ram_write_enabler (out, 1), ram_addr (out, 32), ram_select (out, 4), ram_data_input (out, 32), ram_data_output (in, 32): drive the byte-lane RAM; the RAM writes on the clk edge and reads combinationally.

Function
REQ-014 SHALL implement FSM IDLE -> ACCESS -> RESP -> IDLE; req_ready = 1 only in IDLE.
REQ-015 SHALL accept a request on an edge where req_valid && req_ready, latching all req_* fields.
REQ-016 SHALL fault when size = 11, when size = 01 and addr[0] = 1, or when size = 10 and addr[1:0] != 00; a faulting request goes IDLE -> RESP directly with no RAM enable.
REQ-017 SHALL, in ACCESS, assert ram_enabler = 1, ram_write_enabler = latched write, ram_addr = latched addr with bits [1:0] forced to 00; all ram_* outputs SHALL be 0 in every other state.
REQ-018 SHALL use lane k = bits [8k+7:8k], with byte address offset k mapped to lane k: byte select = 1 << addr[1:0]; half select = 0011 (addr[1] = 0) or 1100 (addr[1] = 1); word select = 1111; loads drive the same select.
REQ-019 SHALL drive ram_data_input for stores as byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word wdata.
REQ-020 SHALL register the load result at the end of ACCESS: the selected lane(s) shifted to bit 0, then sign-extended, or zero-extended when req_unsigned = 1.
REQ-021 SHALL assert resp_valid for exactly the RESP cycle; load latency is acceptance edge N to resp_valid high in cycle N+2, and a fault responds in cycle N+1.
REQ-022 SHALL ignore req_valid outside IDLE; back-to-back requests SHALL have a throughput of one per 3 cycles.

Reset
REQ-023 SHALL, while rst = 1, force state to IDLE and every output to 0 except req_ready, which SHALL be 1 after rst deasserts.
REQ-024 SHALL, on rst asserted during ACCESS, drop ram_enabler asynchronously so that a pending store is not committed and no response is issued.

Structure
REQ-025 SHALL take size codes (SZ_BYTE, SZ_HALF, SZ_WORD) and the FSM state encoding from shared package mips_mem_pkg.
REQ-026 SHALL place lane extraction and extension in one combinational sub-module, load_align.

Verification
REQ-027 SW addr 0x100, wdata 0xDEADBEEF -> ram_select 1111 in ACCESS; then LW 0x100 -> resp_rdata 0xDEADBEEF, resp_valid 2 cycles after acceptance.
REQ-028 SB addr 0x203, wdata 0x000000A5 -> select 1000, ram_data_input 0xA5A5A5A5; LB 0x203 -> 0xFFFFFFA5; LBU 0x203 -> 0x000000A5.
REQ-029 SH addr 0x302, wdata 0x00008001 -> select 1100; LH 0x302 -> 0xFFFF8001; LHU 0x302 -> 0x00008001.
REQ-030 LW addr 0x102; LH addr 0x101; size 11 -> resp_fault = 1 one cycle after acceptance, ram_enabler never asserted, resp_rdata 0.
REQ-031 rst pulsed during the ACCESS cycle of SW 0x400 -> no response; a subsequent LW 0x400 returns the pre-store value.
REQ-032 req_valid held high for 9 cycles -> exactly 3 requests accepted, req_ready low in ACCESS and RESP.
